// File: rtl/ex_mem_stage_pkg.sv
// Shared definitions for the EX stage and EX/MEM pipeline register:
// ALUop and func encodings, ALU select enum, register-0 constant.
package ex_mem_stage_pkg;

  localparam logic [2:0] ALUOP_ADD  = 3'b000;
  localparam logic [2:0] ALUOP_SUB  = 3'b001;
  localparam logic [2:0] ALUOP_OR   = 3'b010;
  localparam logic [2:0] ALUOP_AND  = 3'b011;
  localparam logic [2:0] ALUOP_SLT  = 3'b100;
  localparam logic [2:0] ALUOP_SLTU = 3'b101;

  localparam logic [5:0] FUNC_ADD  = 6'b100000;
  localparam logic [5:0] FUNC_SUB  = 6'b100010;
  localparam logic [5:0] FUNC_AND  = 6'b100100;
  localparam logic [5:0] FUNC_OR   = 6'b100101;
  localparam logic [5:0] FUNC_SLT  = 6'b101010;
  localparam logic [5:0] FUNC_SLTU = 6'b101011;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT,
    ALU_SLTU
  } alu_sel_e;

  // R-type instructions select by func, everything else by the decoder's ALUop.
  // Unknown encodings fall back to add.
  function automatic alu_sel_e decode_alu(input logic r_type,
                                          input logic [5:0] func,
                                          input logic [2:0] aluop);
    alu_sel_e sel;
    sel = ALU_ADD;
    if (r_type) begin
      case (func)
        FUNC_SUB:  sel = ALU_SUB;
        FUNC_AND:  sel = ALU_AND;
        FUNC_OR:   sel = ALU_OR;
        FUNC_SLT:  sel = ALU_SLT;
        FUNC_SLTU: sel = ALU_SLTU;
        default:   sel = ALU_ADD;
      endcase
    end else begin
      case (aluop)
        ALUOP_SUB:  sel = ALU_SUB;
        ALUOP_OR:   sel = ALU_OR;
        ALUOP_AND:  sel = ALU_AND;
        ALUOP_SLT:  sel = ALU_SLT;
        ALUOP_SLTU: sel = ALU_SLTU;
        default:    sel = ALU_ADD;
      endcase
    end
    return sel;
  endfunction

endpackage

// File: rtl/ex_mem_stage_if.sv
// ID/EX operands, write-back forwarding source, PC redirect and EX/MEM outputs.
interface ex_mem_stage_if;
  logic [31:0] EX_PC4, EX_Jtarg, EX_busA, EX_busB;
  logic [4:0]  EX_Rs, EX_Rt, EX_Rd;
  logic [5:0]  EX_func;
  logic [15:0] EX_immd;
  logic [2:0]  EX_ALUop;
  logic        EX_RegWr, EX_ALUSrc, EX_RegDst, EX_MemtoReg, EX_MemWr;
  logic        EX_Branch, EX_Jump, EX_ExtOp, EX_R_type;
  logic        WB_RegWr;
  logic [4:0]  WB_Rw;
  logic [31:0] WB_busW;
  logic        PCSrc;
  logic [31:0] NextPC;
  logic        Flush;
  logic [31:0] MEM_ALUout, MEM_busB;
  logic [4:0]  MEM_Rw;
  logic        MEM_RegWr, MEM_MemtoReg, MEM_MemWr;

  modport master (
    output EX_PC4, EX_Jtarg, EX_busA, EX_busB, EX_Rs, EX_Rt, EX_Rd,
           EX_func, EX_immd, EX_ALUop, EX_RegWr, EX_ALUSrc, EX_RegDst,
           EX_MemtoReg, EX_MemWr, EX_Branch, EX_Jump, EX_ExtOp, EX_R_type,
           WB_RegWr, WB_Rw, WB_busW,
    input  PCSrc, NextPC, Flush, MEM_ALUout, MEM_busB, MEM_Rw,
           MEM_RegWr, MEM_MemtoReg, MEM_MemWr
  );

  modport slave (
    input  EX_PC4, EX_Jtarg, EX_busA, EX_busB, EX_Rs, EX_Rt, EX_Rd,
           EX_func, EX_immd, EX_ALUop, EX_RegWr, EX_ALUSrc, EX_RegDst,
           EX_MemtoReg, EX_MemWr, EX_Branch, EX_Jump, EX_ExtOp, EX_R_type,
           WB_RegWr, WB_Rw, WB_busW,
    output PCSrc, NextPC, Flush, MEM_ALUout, MEM_busB, MEM_Rw,
           MEM_RegWr, MEM_MemtoReg, MEM_MemWr
  );
endinterface

// File: rtl/ex_mem_stage_alu32.sv
// 32-bit combinational ALU. zero_o compares a_i against the register operand
// cmp_b_i rather than b_i, so an immediate on the B port never affects branches.
module alu32
  import ex_mem_stage_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [31:0] cmp_b_i,
  input  alu_sel_e    sel_i,
  output logic [31:0] result_o,
  output logic        zero_o
);

  // Result select; arithmetic wraps, no overflow detection.
  always_comb begin
    result_o = a_i + b_i;
    case (sel_i)
      ALU_SUB:  result_o = a_i - b_i;
      ALU_AND:  result_o = a_i & b_i;
      ALU_OR:   result_o = a_i | b_i;
      ALU_SLT:  result_o = {31'd0, ($signed(a_i) < $signed(b_i))};
      ALU_SLTU: result_o = {31'd0, (a_i < b_i)};
      default:  result_o = a_i + b_i;
    endcase
  end

  assign zero_o = (a_i == cmp_b_i);

endmodule

// File: rtl/ex_mem_stage.sv
// EX stage with operand forwarding, branch/jump resolution and the EX/MEM
// pipeline register. State updates on the falling edge of Clk.
module ex_mem_stage
  import ex_mem_stage_pkg::*;
(
  input logic          Clk,
  input logic          Clr,
  ex_mem_stage_if.slave bus
);

  logic [31:0] fwd_a, fwd_b, imm_ext, alu_b, alu_res, br_target;
  logic        zero, br_taken;
  alu_sel_e    alu_sel;

  logic [31:0] alu_out_q, alu_out_d, bus_b_q, bus_b_d;
  logic [4:0]  rw_q, rw_d;
  logic        regwr_q, regwr_d, memtoreg_q, memtoreg_d, memwr_q, memwr_d;

  // Operand forwarding: a load in MEM has no data yet, so only ALU results
  // forward from MEM; MEM wins over WB; register 0 never forwards.
  always_comb begin
    fwd_a = bus.EX_busA;
    fwd_b = bus.EX_busB;
    if (regwr_q && !memtoreg_q && rw_q != REG_ZERO && rw_q == bus.EX_Rs)
      fwd_a = alu_out_q;
    else if (bus.WB_RegWr && bus.WB_Rw != REG_ZERO && bus.WB_Rw == bus.EX_Rs)
      fwd_a = bus.WB_busW;
    if (regwr_q && !memtoreg_q && rw_q != REG_ZERO && rw_q == bus.EX_Rt)
      fwd_b = alu_out_q;
    else if (bus.WB_RegWr && bus.WB_Rw != REG_ZERO && bus.WB_Rw == bus.EX_Rt)
      fwd_b = bus.WB_busW;
  end

  assign imm_ext = bus.EX_ExtOp ? {{16{bus.EX_immd[15]}}, bus.EX_immd}
                                : {16'd0, bus.EX_immd};
  assign alu_b   = bus.EX_ALUSrc ? imm_ext : fwd_b;
  assign alu_sel = decode_alu(bus.EX_R_type, bus.EX_func, bus.EX_ALUop);

  alu32 u_alu (
    .a_i      (fwd_a),
    .b_i      (alu_b),
    .cmp_b_i  (fwd_b),
    .sel_i    (alu_sel),
    .result_o (alu_res),
    .zero_o   (zero)
  );

  assign br_target = bus.EX_PC4 + {{14{bus.EX_immd[15]}}, bus.EX_immd, 2'b00};
  assign br_taken  = bus.EX_Branch & zero;

  // PC redirect; a jump overrides a simultaneously taken branch.
  always_comb begin
    bus.PCSrc  = br_taken | bus.EX_Jump;
    bus.NextPC = bus.EX_Jump ? bus.EX_Jtarg : br_target;
    bus.Flush  = br_taken | bus.EX_Jump;
  end

  // Next values for the EX/MEM register; store data is the forwarded B.
  always_comb begin
    alu_out_d  = alu_res;
    bus_b_d    = fwd_b;
    rw_d       = bus.EX_RegDst ? bus.EX_Rd : bus.EX_Rt;
    regwr_d    = bus.EX_RegWr;
    memtoreg_d = bus.EX_MemtoReg;
    memwr_d    = bus.EX_MemWr;
  end

  // EX/MEM register, cleared asynchronously by Clr.
  always_ff @(negedge Clk or posedge Clr) begin
    if (Clr) begin
      alu_out_q  <= '0;
      bus_b_q    <= '0;
      rw_q       <= '0;
      regwr_q    <= 1'b0;
      memtoreg_q <= 1'b0;
      memwr_q    <= 1'b0;
    end else begin
      alu_out_q  <= alu_out_d;
      bus_b_q    <= bus_b_d;
      rw_q       <= rw_d;
      regwr_q    <= regwr_d;
      memtoreg_q <= memtoreg_d;
      memwr_q    <= memwr_d;
    end
  end

  assign bus.MEM_ALUout   = alu_out_q;
  assign bus.MEM_busB     = bus_b_q;
  assign bus.MEM_Rw       = rw_q;
  assign bus.MEM_RegWr    = regwr_q;
  assign bus.MEM_MemtoReg = memtoreg_q;
  assign bus.MEM_MemWr    = memwr_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: inputs driven on posedge, MEM_* sampled
// 1 time unit after the falling edge that captures them.
module tb_ex_mem_stage;
  import ex_mem_stage_pkg::*;

  logic Clk, Clr;
  int total = 0;
  int bad = 0;

  ex_mem_stage_if bus();
  ex_mem_stage dut (.Clk(Clk), .Clr(Clr), .bus(bus));

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic clear_ex();
    bus.EX_PC4 = '0; bus.EX_Jtarg = '0; bus.EX_busA = '0; bus.EX_busB = '0;
    bus.EX_Rs = '0; bus.EX_Rt = '0; bus.EX_Rd = '0; bus.EX_func = '0;
    bus.EX_immd = '0; bus.EX_ALUop = '0; bus.EX_RegWr = 0; bus.EX_ALUSrc = 0;
    bus.EX_RegDst = 0; bus.EX_MemtoReg = 0; bus.EX_MemWr = 0; bus.EX_Branch = 0;
    bus.EX_Jump = 0; bus.EX_ExtOp = 0; bus.EX_R_type = 0;
  endtask

  task automatic set_wb(input logic en, input logic [4:0] rw, input logic [31:0] d);
    bus.WB_RegWr = en; bus.WB_Rw = rw; bus.WB_busW = d;
  endtask

  task automatic set_r(input logic [5:0] func, input logic [4:0] rs, rt, rd,
                       input logic [31:0] a, b);
    clear_ex();
    bus.EX_R_type = 1; bus.EX_RegDst = 1; bus.EX_RegWr = 1; bus.EX_func = func;
    bus.EX_Rs = rs; bus.EX_Rt = rt; bus.EX_Rd = rd; bus.EX_busA = a; bus.EX_busB = b;
  endtask

  task automatic set_i(input logic [2:0] op, input logic ext, input logic [15:0] imm,
                       input logic [4:0] rs, rt, input logic [31:0] a, b);
    clear_ex();
    bus.EX_ALUop = op; bus.EX_ALUSrc = 1; bus.EX_ExtOp = ext; bus.EX_immd = imm;
    bus.EX_RegWr = 1; bus.EX_Rs = rs; bus.EX_Rt = rt; bus.EX_busA = a; bus.EX_busB = b;
  endtask

  task automatic capture();
    @(negedge Clk); #1;
  endtask

  task automatic test_reset();
    Clr = 1;
    clear_ex(); set_wb(0, 0, 0);
    set_r(FUNC_ADD, 1, 2, 3, 5, 7);
    capture();
    total++; if (bus.MEM_ALUout !== 32'd0) begin bad++; $display("FAIL rst_aluout got=%h exp=0", bus.MEM_ALUout); end
    total++; if (bus.MEM_RegWr !== 1'b0) begin bad++; $display("FAIL rst_regwr got=%b exp=0", bus.MEM_RegWr); end
    total++; if (bus.MEM_Rw !== 5'd0) begin bad++; $display("FAIL rst_rw got=%0d exp=0", bus.MEM_Rw); end
    total++; if (bus.MEM_busB !== 32'd0 || bus.MEM_MemWr !== 1'b0 || bus.MEM_MemtoReg !== 1'b0) begin
      bad++; $display("FAIL rst_misc busB=%h memwr=%b m2r=%b exp all 0", bus.MEM_busB, bus.MEM_MemWr, bus.MEM_MemtoReg); end
    bus.EX_Jump = 1; bus.EX_Jtarg = 32'h0000_1234; #1;
    total++; if (bus.PCSrc !== 1'b1 || bus.Flush !== 1'b1) begin bad++; $display("FAIL rst_jump pcsrc=%b flush=%b exp 1 1", bus.PCSrc, bus.Flush); end
    total++; if (bus.NextPC !== 32'h0000_1234) begin bad++; $display("FAIL rst_nextpc got=%h exp=00001234", bus.NextPC); end
    @(posedge Clk); Clr = 0; clear_ex();
  endtask

  task automatic test_alu_ops();
    @(posedge Clk); set_r(FUNC_ADD, 1, 2, 3, 5, 7); capture();
    total++; if (bus.MEM_ALUout !== 32'd12) begin bad++; $display("FAIL add got=%h exp=0000000c", bus.MEM_ALUout); end
    total++; if (bus.MEM_Rw !== 5'd3 || bus.MEM_RegWr !== 1'b1) begin bad++; $display("FAIL add_dst rw=%0d regwr=%b exp 3 1", bus.MEM_Rw, bus.MEM_RegWr); end
    @(posedge Clk); set_r(FUNC_SLT, 8, 9, 10, 32'hFFFF_FFFF, 1); capture();
    total++; if (bus.MEM_ALUout !== 32'd1) begin bad++; $display("FAIL slt got=%h exp=1", bus.MEM_ALUout); end
    @(posedge Clk); set_r(FUNC_SLTU, 8, 9, 11, 32'hFFFF_FFFF, 1); capture();
    total++; if (bus.MEM_ALUout !== 32'd0) begin bad++; $display("FAIL sltu got=%h exp=0", bus.MEM_ALUout); end
    @(posedge Clk); set_r(FUNC_ADD, 8, 9, 12, 32'hFFFF_FFFF, 1); capture();
    total++; if (bus.MEM_ALUout !== 32'd0) begin bad++; $display("FAIL add_wrap got=%h exp=0", bus.MEM_ALUout); end
    @(posedge Clk); set_r(FUNC_SUB, 8, 9, 13, 3, 5); capture();
    total++; if (bus.MEM_ALUout !== 32'hFFFF_FFFE) begin bad++; $display("FAIL sub got=%h exp=fffffffe", bus.MEM_ALUout); end
    @(posedge Clk); set_r(FUNC_AND, 8, 9, 14, 32'hF0F0, 32'hFF00); capture();
    total++; if (bus.MEM_ALUout !== 32'h0000_F000) begin bad++; $display("FAIL and got=%h exp=0000f000", bus.MEM_ALUout); end
    @(posedge Clk); set_r(FUNC_OR, 8, 9, 15, 32'hF0F0, 32'hFF00); capture();
    total++; if (bus.MEM_ALUout !== 32'h0000_FFF0) begin bad++; $display("FAIL or got=%h exp=0000fff0", bus.MEM_ALUout); end
    @(posedge Clk); set_r(6'b000000, 8, 9, 16, 2, 3); capture();
    total++; if (bus.MEM_ALUout !== 32'd5) begin bad++; $display("FAIL func_default got=%h exp=5", bus.MEM_ALUout); end
    @(posedge Clk); set_i(ALUOP_ADD, 1, 16'hFFFE, 8, 17, 10, 32'hDEAD); capture();
    total++; if (bus.MEM_ALUout !== 32'd8) begin bad++; $display("FAIL addi_sext got=%h exp=8", bus.MEM_ALUout); end
    total++; if (bus.MEM_Rw !== 5'd17) begin bad++; $display("FAIL addi_rt got=%0d exp=17", bus.MEM_Rw); end
    @(posedge Clk); set_i(ALUOP_OR, 0, 16'h8001, 8, 18, 32'h0001_0000, 0); capture();
    total++; if (bus.MEM_ALUout !== 32'h0001_8001) begin bad++; $display("FAIL ori_zext got=%h exp=00018001", bus.MEM_ALUout); end
    @(posedge Clk); set_i(ALUOP_SLT, 1, 16'hFFFF, 8, 19, 32'hFFFF_FFFE, 0); capture();
    total++; if (bus.MEM_ALUout !== 32'd1) begin bad++; $display("FAIL slti got=%h exp=1", bus.MEM_ALUout); end
  endtask

  task automatic test_forwarding();
    set_wb(0, 0, 0);
    @(posedge Clk); set_r(FUNC_ADD, 1, 2, 3, 5, 7); capture();
    @(posedge Clk); set_r(FUNC_SUB, 3, 1, 4, 0, 5); capture();
    total++; if (bus.MEM_ALUout !== 32'd7) begin bad++; $display("FAIL fwd_mem_a got=%h exp=7", bus.MEM_ALUout); end
    total++; if (bus.MEM_busB !== 32'd5) begin bad++; $display("FAIL fwd_busb got=%h exp=5", bus.MEM_busB); end
    @(posedge Clk); set_r(FUNC_ADD, 1, 2, 3, 5, 7); capture();
    @(posedge Clk); set_r(FUNC_ADD, 3, 0, 5, 0, 0); set_wb(1, 3, 99); capture();
    total++; if (bus.MEM_ALUout !== 32'd12) begin bad++; $display("FAIL fwd_mem_over_wb got=%0d exp=12", bus.MEM_ALUout); end
    @(posedge Clk); set_r(FUNC_ADD, 0, 3, 6, 0, 0); set_wb(1, 3, 99); capture();
    total++; if (bus.MEM_ALUout !== 32'd99) begin bad++; $display("FAIL fwd_wb_b got=%0d exp=99", bus.MEM_ALUout); end
    @(posedge Clk); set_r(FUNC_ADD, 6, 6, 7, 1, 1); set_wb(0, 0, 0); capture();
    total++; if (bus.MEM_ALUout !== 32'd198 || bus.MEM_busB !== 32'd99) begin
      bad++; $display("FAIL fwd_rs_eq_rt got=%0d busB=%0d exp 198 99", bus.MEM_ALUout, bus.MEM_busB); end
    @(posedge Clk); set_i(ALUOP_ADD, 1, 16'h0000, 0, 8, 32'h40, 0); bus.EX_MemtoReg = 1; capture();
    total++; if (bus.MEM_MemtoReg !== 1'b1 || bus.MEM_ALUout !== 32'h40) begin
      bad++; $display("FAIL load_ctrl m2r=%b addr=%h exp 1 00000040", bus.MEM_MemtoReg, bus.MEM_ALUout); end
    @(posedge Clk); set_r(FUNC_ADD, 8, 9, 10, 3, 4); set_wb(1, 8, 40); capture();
    total++; if (bus.MEM_ALUout !== 32'd44) begin bad++; $display("FAIL fwd_skip_load got=%0d exp=44", bus.MEM_ALUout); end
    @(posedge Clk); set_r(FUNC_ADD, 1, 2, 0, 5, 7); set_wb(0, 0, 0); capture();
    total++; if (bus.MEM_Rw !== 5'd0 || bus.MEM_ALUout !== 32'd12) begin
      bad++; $display("FAIL r0_dst rw=%0d res=%0d exp 0 12", bus.MEM_Rw, bus.MEM_ALUout); end
    @(posedge Clk); set_r(FUNC_ADD, 0, 0, 9, 32'h11, 32'h22); set_wb(1, 0, 99); capture();
    total++; if (bus.MEM_ALUout !== 32'h33) begin bad++; $display("FAIL no_fwd_r0 got=%h exp=00000033", bus.MEM_ALUout); end
    @(posedge Clk); set_i(ALUOP_ADD, 1, 16'h0004, 1, 9, 32'h100, 0);
    bus.EX_RegWr = 0; bus.EX_MemWr = 1; set_wb(0, 0, 0); capture();
    total++; if (bus.MEM_ALUout !== 32'h104 || bus.MEM_busB !== 32'h33) begin
      bad++; $display("FAIL store_fwd addr=%h data=%h exp 00000104 00000033", bus.MEM_ALUout, bus.MEM_busB); end
    total++; if (bus.MEM_MemWr !== 1'b1 || bus.MEM_RegWr !== 1'b0) begin
      bad++; $display("FAIL store_ctrl memwr=%b regwr=%b exp 1 0", bus.MEM_MemWr, bus.MEM_RegWr); end
  endtask

  task automatic test_branch();
    @(posedge Clk); clear_ex(); bus.EX_Branch = 1; bus.EX_Rs = 20; bus.EX_Rt = 21;
    bus.EX_busA = 9; bus.EX_busB = 9; bus.EX_immd = 16'hFFFF; bus.EX_PC4 = 32'h100; #1;
    total++; if (bus.PCSrc !== 1'b1 || bus.Flush !== 1'b1) begin bad++; $display("FAIL beq_taken pcsrc=%b flush=%b exp 1 1", bus.PCSrc, bus.Flush); end
    total++; if (bus.NextPC !== 32'h0000_00FC) begin bad++; $display("FAIL beq_target got=%h exp=000000fc", bus.NextPC); end
    bus.EX_busB = 8; #1;
    total++; if (bus.PCSrc !== 1'b0 || bus.Flush !== 1'b0) begin bad++; $display("FAIL beq_not_taken pcsrc=%b flush=%b exp 0 0", bus.PCSrc, bus.Flush); end
    bus.EX_busB = 9; bus.EX_immd = 16'h0004; bus.EX_PC4 = 32'h200; #1;
    total++; if (bus.NextPC !== 32'h0000_0210) begin bad++; $display("FAIL beq_fwd_target got=%h exp=00000210", bus.NextPC); end
    bus.EX_Jump = 1; bus.EX_Jtarg = 32'h0040_0000; #1;
    total++; if (bus.NextPC !== 32'h0040_0000 || bus.PCSrc !== 1'b1) begin
      bad++; $display("FAIL jump_wins npc=%h pcsrc=%b exp 00400000 1", bus.NextPC, bus.PCSrc); end
    bus.EX_Branch = 0; bus.EX_busB = 8; #1;
    total++; if (bus.PCSrc !== 1'b1 || bus.Flush !== 1'b1) begin bad++; $display("FAIL jump_only pcsrc=%b flush=%b exp 1 1", bus.PCSrc, bus.Flush); end
  endtask

  task automatic test_bubble();
    @(posedge Clk); clear_ex(); set_wb(0, 0, 0); capture();
    total++; if (bus.MEM_ALUout !== 32'd0 || bus.MEM_busB !== 32'd0 || bus.MEM_Rw !== 5'd0) begin
      bad++; $display("FAIL bubble_data res=%h busB=%h rw=%0d exp 0 0 0", bus.MEM_ALUout, bus.MEM_busB, bus.MEM_Rw); end
    total++; if (bus.MEM_RegWr !== 1'b0 || bus.MEM_MemWr !== 1'b0 || bus.MEM_MemtoReg !== 1'b0) begin
      bad++; $display("FAIL bubble_ctrl regwr=%b memwr=%b m2r=%b exp 0 0 0", bus.MEM_RegWr, bus.MEM_MemWr, bus.MEM_MemtoReg); end
  endtask

  task automatic test_reset_mid();
    @(posedge Clk); set_r(FUNC_ADD, 1, 2, 3, 5, 7); capture();
    total++; if (bus.MEM_ALUout !== 32'd12) begin bad++; $display("FAIL mid_pre got=%0d exp=12", bus.MEM_ALUout); end
    @(posedge Clk); set_r(FUNC_ADD, 1, 2, 4, 1, 2);
    #1 Clr = 1; #1;
    total++; if (bus.MEM_ALUout !== 32'd0 || bus.MEM_RegWr !== 1'b0 || bus.MEM_Rw !== 5'd0) begin
      bad++; $display("FAIL mid_clear res=%h regwr=%b rw=%0d exp 0 0 0", bus.MEM_ALUout, bus.MEM_RegWr, bus.MEM_Rw); end
    #1 Clr = 0;
    capture();
    total++; if (bus.MEM_ALUout !== 32'd3 || bus.MEM_Rw !== 5'd4 || bus.MEM_RegWr !== 1'b1) begin
      bad++; $display("FAIL mid_recover res=%0d rw=%0d regwr=%b exp 3 4 1", bus.MEM_ALUout, bus.MEM_Rw, bus.MEM_RegWr); end
  endtask

  initial begin
    test_reset();
    test_alu_ops();
    test_forwarding();
    test_branch();
    test_bubble();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
